// File: rtl/mul16_seq_if.sv
// mul16_seq_if: start/busy/done handshake and operand/result bus of mul16_seq.
interface mul16_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [15:0] product_hi;
  modport master (output start, a, b, input busy, done, product, product_hi);
  modport slave (input start, a, b, output busy, done, product, product_hi);
endinterface

// File: rtl/mul16_seq.sv
// mul16_seq: 16-cycle shift-add 16x16 multiplier around add16; MUL16_FULL_PRODUCT_EN adds the high product half.
module add16 (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  output logic [15:0] s_o
);
  assign s_o = x_i + y_i;
endmodule

module mul16_seq (
  input logic         clk,
  input logic         rst_n,
  mul16_seq_if.slave  bus
);
`ifdef MUL16_FULL_PRODUCT_EN
  localparam int AW = 32;
`else
  localparam int AW = 16;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, mcand_q, mcand_d, sum;
  logic [15:0]   mplier_q, mplier_d, product_q, product_d, s_lo;
  logic [3:0]    cnt_q, cnt_d;
  logic          last;
  add16 u_lo (.x_i(acc_q[15:0]), .y_i(mcand_q[15:0]), .s_o(s_lo));
`ifdef MUL16_FULL_PRODUCT_EN
  logic        c;
  logic [15:0] t_hi, s_hi, product_hi_q;
  // carry out of the low adder recovered from its operand and sum msbs
  assign c = (acc_q[15] & mcand_q[15]) | ((acc_q[15] | mcand_q[15]) & ~s_lo[15]);
  add16 u_hi (.x_i(acc_q[31:16]), .y_i(mcand_q[31:16]), .s_o(t_hi));
  add16 u_cy (.x_i(t_hi), .y_i({15'd0, c}), .s_o(s_hi));
  assign sum = {s_hi, s_lo};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) product_hi_q <= '0;
    else if (last) product_hi_q <= acc_d[31:16];
  assign bus.product_hi = product_hi_q;
`else
  assign sum = s_lo;
  assign bus.product_hi = 16'h0000;
`endif
  assign last = (state_q == RUN) && (cnt_q == 4'd15);
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (state_q == RUN) begin
      acc_d    = mplier_q[0] ? sum : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 4'd1;
      state_d  = last ? DONE : RUN;
      product_d = last ? acc_d[15:0] : product_q;
    end else if (bus.start) begin
      state_d  = RUN;
      acc_d    = '0;
      mcand_d  = AW'(bus.a);
      mplier_d = bus.b;
      cnt_d    = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  assign bus.busy    = state_q == RUN;
  assign bus.done    = state_q == DONE;
  assign bus.product = product_q;
endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: vector table, random ops against a*b, and handshake corner sequences for mul16_seq.
module tb_mul16_seq;
`ifdef MUL16_FULL_PRODUCT_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  logic clk, rst_n;
  int n_chk, n_fail;
  mul16_seq_if bus ();
  mul16_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct {
    logic [15:0] a, b, lo, hi;
  } vec_t;
  vec_t tv[4];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic do_op(input logic [15:0] a, b, lo, hi, input string nm);
    int n, nb;
    start_op(a, b);
    n = 0; nb = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd16);
    chk({nm, "_busy_cycles"}, 32'(nb), 32'd16);
    chk({nm, "_lo"}, 32'(bus.product), 32'(lo));
    chk({nm, "_hi"}, 32'(bus.product_hi), 32'(hi));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({nm, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask
  initial begin
    int n, dn;
    logic [15:0] ra, rb;
    logic [31:0] full;
    n_chk = 0; n_fail = 0;
    tv[0] = '{16'd3, 16'd5, 16'h000F, 16'h0000};
    tv[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, FP ? 16'hFFFE : 16'h0000};
    tv[2] = '{16'h0100, 16'h0100, 16'h0000, FP ? 16'h0001 : 16'h0000};
    tv[3] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000};
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_product_hi", 32'(bus.product_hi), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_op(tv[i].a, tv[i].b, tv[i].lo, tv[i].hi, $sformatf("vec%0d", i));
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      full = {16'd0, ra} * {16'd0, rb};
      do_op(ra, rb, full[15:0], FP ? full[31:16] : 16'h0000, $sformatf("rnd%0d", i));
    end
    start_op(16'd7, 16'd9);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd2; bus.b = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    chk("ign_done_seen", 32'(n < 40), 32'd1);
    chk("ign_product", 32'(bus.product), 32'h003F);
    chk("ign_product_hi", 32'(bus.product_hi), 32'h0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("ign_hold%0d", i), 32'(bus.product), 32'h003F);
    end
    chk("ign_not_restarted", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd6; bus.b = 16'd7;
    @(negedge clk);
    bus.a = 16'd10; bus.b = 16'd10;
    wait_done(n);
    chk("b2b_first_latency", 32'(n), 32'd16);
    chk("b2b_first_product", 32'(bus.product), 32'h002A);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_accept_busy", 32'(bus.busy), 32'd1);
    chk("b2b_accept_done", 32'(bus.done), 32'd0);
    chk("b2b_product_held", 32'(bus.product), 32'h002A);
    wait_done(n);
    chk("b2b_second_latency", 32'(n), 32'd16);
    chk("b2b_second_product", 32'(bus.product), 32'h0064);
    @(negedge clk);
    start_op(16'd4, 16'd4);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_product", 32'(bus.product), 32'd0);
    chk("arst_product_hi", 32'(bus.product_hi), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    chk("arst_no_resume", 32'(dn), 32'd0);
    do_op(16'd2, 16'd3, 16'h0006, 16'h0000, "post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
